ctc_ws_gen: RTL and testbench
=============================

Name: ctc_ws_gen

Overview:
- Parametrised control/timing and word-select generator for the serial-digit calculator datapath.
- Runs the frame counter (NDIGIT digits × DBITS bits per digit) and samples the serial instruction stream `is` during the sync window.
- Holds and updates the digit pointer, and drives `ws` for the full field set (p, wp, xs, x, s, m, ms, w).
- Generalises the earlier CTC pointer/ws logic to configurable word geometry, with pointer arithmetic and pointer test.

Parameters:
- NDIGIT, 14: digits per word.
- DBITS, 4: bit-times per digit.
- EXP_DIGITS, 3: low digits forming the exponent field (x), with xs at digit EXP_DIGITS-1.
- IS_START, 45: bit-time at which the instruction window opens.
- IS_LEN, 10: instruction length in bits.
- PTR_W, 4: pointer width; must satisfy 2^PTR_W >= NDIGIT.

Ports:
- cph2, input, 1: system clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- is, input, 1: serial instruction bit, LSB first, valid while sync=1.
- sync, output, 1: high for bit-times IS_START..IS_START+IS_LEN-1.
- ws, output, 1: word select for the current bit-time.
- digit, output, PTR_W: current digit index (count / DBITS).
- t_last, output, 1: high on the last bit-time of each digit.
- ptr, output, PTR_W: current pointer value.
- tst_flag, output, 1: result of the most recent pointer test, registered.

Behaviour:
- Counter:
  - FRAME = NDIGIT*DBITS; counter width is clog2(FRAME).
  - Counts 0..FRAME-1, then wraps to 0; it never stops.
  - digit and t_last are decoded combinationally from the counter.
- Instruction fetch:
  - Shift register is_sr[IS_LEN-1:0].
  - While sync=1, each cycle performs is_sr <= {is, is_sr[IS_LEN-1:1]}. After the window, is_sr[0] holds the first bit received.
  - is_sr holds its value outside the window.
- Decode point: at count FRAME-1, is_sr is decoded. The resulting ws mode and pointer update take effect from count 0 of the next frame, so there is exactly one frame of latency.
- Field instruction (is_sr[1:0] = 2'b10):
  - ws_en <= 1; field <= is_sr[4:2].
  - Field codes: 000 p, 001 wp, 010 xs, 011 x, 100 s, 101 m, 110 w, 111 ms.
- Pointer instruction (is_sr[1:0] = 2'b00). N = is_sr[9:6]; subop = is_sr[5:2]:
  - 0011 (set): ptr <= N if N < NDIGIT. If N >= NDIGIT, ptr is unchanged.
  - 1011 (test): tst_flag <= (ptr == N).
  - 0111 (dec): ptr <= ptr-1, wrapping from 0 to NDIGIT-1.
  - 1111 (inc): ptr <= ptr+1, wrapping from NDIGIT-1 to 0.
  - For any pointer instruction, ws_en <= 0.
- Any other instruction: ws_en <= 0; ptr unchanged.
- tst_flag:
  - Updated only by a test instruction.
  - Cleared to 0 at the decode point of any non-test instruction, so it is valid for exactly one frame.
- ws generation:
  - ws = ws_en & in_field(digit, field, ptr), held for all DBITS bit-times of each selected digit.
  - Field ranges:
    - p: digit == ptr.
    - wp: digit <= ptr (digits 0 through ptr inclusive).
    - xs: digit == EXP_DIGITS-1.
    - x: digit <= EXP_DIGITS-1.
    - m: EXP_DIGITS <= digit <= NDIGIT-2.
    - ms: EXP_DIGITS <= digit <= NDIGIT-1.
    - s: digit == NDIGIT-1.
    - w: all digits.
- Pointer change and ws: ptr changes only at the frame boundary, so p/wp masks never glitch mid-frame.
- Reset (rst=1):
  - counter = 0, is_sr = 0, ptr = 0, ws_en = 0, field = 000, tst_flag = 0.
  - Outputs: ws = 0, sync = 0, digit = 0, t_last = 0 (DBITS > 1).
- Reset mid-frame: the frame restarts at count 0 and any partially shifted instruction is discarded.

Decomposition:
- Package ctc_pkg holds:
  - field code constants (FLD_P, FLD_WP, FLD_XS, FLD_X, FLD_S, FLD_M, FLD_W, FLD_MS);
  - instruction type constants (TYP_FIELD = 2'b10, TYP_PTR = 2'b00);
  - pointer subop constants (SUB_SET, SUB_TST, SUB_DEC, SUB_INC).
- One combinational sub-module, ctc_field_mask: inputs digit, field, ptr; output in_field; parametrised by NDIGIT and EXP_DIGITS.

Test Plan:
- Frame timing: release reset, run 3 frames with defaults -> sync high for counts 45..54 only, period 56; t_last at counts 3, 7, ..., 55; digit steps 0..13.
- Set/wp: send set N=5, then a field instruction with code 001 -> in the frame after the field fetch, ws high for counts 0..23 and low for 24..55.
- Pointer wrap: set 13, then inc -> ptr=0; then dec -> ptr=13; then set 14 -> ptr stays 13.
- Test: with ptr=7, send test N=7 -> tst_flag=1 for one frame; the following non-test instruction -> 0. With N=6 -> tst_flag=0.
- Fields: send codes 011, 010, 111, 100 -> ws high for counts 0..11, 8..11, 12..55, 52..55 respectively; run the same with NDIGIT=16, EXP_DIGITS=2 -> x covers counts 0..7, s covers 60..63.
- Reset mid-frame: assert rst at count 50 during a fetch -> next frame ws=0, ptr=0, counter restarts at 0.

Source files
------------

// File: rtl/ctc_pkg.sv
// Shared encodings for the serial-digit control/timing block: field codes,
// instruction types and pointer sub-operations.
package ctc_pkg;

    typedef enum logic [2:0] {
        FLD_P  = 3'b000,
        FLD_WP = 3'b001,
        FLD_XS = 3'b010,
        FLD_X  = 3'b011,
        FLD_S  = 3'b100,
        FLD_M  = 3'b101,
        FLD_W  = 3'b110,
        FLD_MS = 3'b111
    } field_t;

    localparam logic [1:0] TYP_FIELD = 2'b10;
    localparam logic [1:0] TYP_PTR   = 2'b00;

    localparam logic [3:0] SUB_SET = 4'b0011;
    localparam logic [3:0] SUB_TST = 4'b1011;
    localparam logic [3:0] SUB_DEC = 4'b0111;
    localparam logic [3:0] SUB_INC = 4'b1111;

endpackage

// File: rtl/ctc_ws_gen_if.sv
// Bundle between the timing generator and the serial datapath it paces.
// No handshake: `is` is sampled on every rising clock while `sync` is high;
// all other signals are outputs of the generator valid for the current bit-time.
interface ctc_ws_gen_if #(
    parameter int PTR_W = 4
);
    logic             is;
    logic             sync;
    logic             ws;
    logic [PTR_W-1:0] digit;
    logic             t_last;
    logic [PTR_W-1:0] ptr;
    logic             tst_flag;

    modport master (
        input  is,
        output sync, ws, digit, t_last, ptr, tst_flag
    );

    modport slave (
        output is,
        input  sync, ws, digit, t_last, ptr, tst_flag
    );
endinterface

// File: rtl/ctc_field_mask.sv
// Combinational digit-range test: is the current digit inside the selected field?
module ctc_field_mask
    import ctc_pkg::*;
#(
    parameter int NDIGIT     = 14,
    parameter int EXP_DIGITS = 3,
    parameter int PTR_W      = 4
) (
    input  logic [PTR_W-1:0] digit,
    input  field_t           field,
    input  logic [PTR_W-1:0] ptr,
    output logic             in_field
);
    localparam logic [PTR_W-1:0] XS_D = PTR_W'(EXP_DIGITS - 1);
    localparam logic [PTR_W-1:0] M_LO = PTR_W'(EXP_DIGITS);
    localparam logic [PTR_W-1:0] M_HI = PTR_W'(NDIGIT - 2);
    localparam logic [PTR_W-1:0] S_D  = PTR_W'(NDIGIT - 1);

    // digit never exceeds NDIGIT-1, so ms and w need no upper bound test
    always_comb begin
        in_field = 1'b0;
        unique case (field)
            FLD_P:   in_field = (digit == ptr);
            FLD_WP:  in_field = (digit <= ptr);
            FLD_XS:  in_field = (digit == XS_D);
            FLD_X:   in_field = (digit <= XS_D);
            FLD_M:   in_field = (digit >= M_LO) && (digit <= M_HI);
            FLD_MS:  in_field = (digit >= M_LO);
            FLD_S:   in_field = (digit == S_D);
            FLD_W:   in_field = 1'b1;
            default: in_field = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctc_ws_gen.sv
// Frame counter, serial instruction fetch, digit pointer and word-select
// generation for the serial-digit calculator datapath.
module ctc_ws_gen
    import ctc_pkg::*;
#(
    parameter int NDIGIT     = 14,
    parameter int DBITS      = 4,
    parameter int EXP_DIGITS = 3,
    parameter int IS_START   = 45,
    parameter int IS_LEN     = 10,
    parameter int PTR_W      = 4
) (
    input  logic          cph2,
    input  logic          rst,
    ctc_ws_gen_if.master  bus
);
    localparam int FRAME = NDIGIT * DBITS;
    localparam int CW    = $clog2(FRAME);

    localparam logic [CW-1:0]    CNT_LAST = CW'(FRAME - 1);
    localparam logic [CW-1:0]    WIN_LO   = CW'(IS_START);
    localparam logic [CW-1:0]    WIN_HI   = CW'(IS_START + IS_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NDIGIT - 1);

    logic [CW-1:0]     count;
    logic [IS_LEN-1:0] is_sr;
    logic [PTR_W-1:0]  ptr_q;
    logic              ws_en;
    field_t            field;
    logic              tst_q;

    logic [PTR_W-1:0]  digit;
    logic              sync;
    logic              in_field;
    logic              frame_end;

    logic [1:0]        typ;
    logic [3:0]        sub;
    logic [3:0]        n;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              ws_en_nxt;
    field_t            field_nxt;
    logic              tst_nxt;

    assign digit     = PTR_W'(count / CW'(DBITS));
    assign sync      = (count >= WIN_LO) && (count <= WIN_HI);
    assign frame_end = (count == CNT_LAST);

    assign typ = is_sr[1:0];
    assign sub = is_sr[5:2];
    assign n   = is_sr[9:6];

    // Decode of the fetched word; committed only at the last bit-time of the
    // frame so pointer-relative masks stay stable for a whole frame.
    always_comb begin
        ptr_nxt   = ptr_q;
        ws_en_nxt = 1'b0;
        field_nxt = field;
        tst_nxt   = 1'b0;
        if (typ == TYP_FIELD) begin
            ws_en_nxt = 1'b1;
            field_nxt = field_t'(is_sr[4:2]);
        end else if (typ == TYP_PTR) begin
            unique case (sub)
                SUB_SET: if (32'(n) < NDIGIT) ptr_nxt = PTR_W'(n);
                SUB_TST: tst_nxt = (32'(ptr_q) == 32'(n));
                SUB_DEC: ptr_nxt = (ptr_q == '0) ? PTR_MAX : ptr_q - PTR_W'(1);
                SUB_INC: ptr_nxt = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
                default: ptr_nxt = ptr_q;
            endcase
        end
    end

    always_ff @(posedge cph2) begin
        if (rst) begin
            count <= '0;
            is_sr <= '0;
            ptr_q <= '0;
            ws_en <= 1'b0;
            field <= FLD_P;
            tst_q <= 1'b0;
        end else begin
            count <= frame_end ? '0 : count + CW'(1);
            if (sync) begin
                is_sr <= {bus.is, is_sr[IS_LEN-1:1]};
            end
            if (frame_end) begin
                ptr_q <= ptr_nxt;
                ws_en <= ws_en_nxt;
                field <= field_nxt;
                tst_q <= tst_nxt;
            end
        end
    end

    ctc_field_mask #(
        .NDIGIT     (NDIGIT),
        .EXP_DIGITS (EXP_DIGITS),
        .PTR_W      (PTR_W)
    ) u_mask (
        .digit    (digit),
        .field    (field),
        .ptr      (ptr_q),
        .in_field (in_field)
    );

    assign bus.sync     = sync;
    assign bus.ws       = ws_en & in_field;
    assign bus.digit    = digit;
    assign bus.t_last   = ((count % CW'(DBITS)) == CW'(DBITS - 1));
    assign bus.ptr      = ptr_q;
    assign bus.tst_flag = tst_q;
endmodule

// File: tb/tb_ctc_ws_gen.sv
// Bench for ctc_ws_gen: default geometry plus a 16-digit, 2-exponent-digit
// variant, each checked bit-time by bit-time against a frame-level model.
module tb_ctc_ws_gen;
    localparam int DBITS    = 4;
    localparam int IS_START = 45;
    localparam int IS_LEN   = 10;
    localparam int ND_A = 14, ED_A = 3;
    localparam int ND_B = 16, ED_B = 2;

    localparam logic [3:0] P_SET = 4'b0011;
    localparam logic [3:0] P_TST = 4'b1011;
    localparam logic [3:0] P_DEC = 4'b0111;
    localparam logic [3:0] P_INC = 4'b1111;

    logic cph2 = 1'b0;
    logic rst_a, rst_b;

    int checks   = 0;
    int failures = 0;

    // model state per configuration (0 = default, 1 = 16-digit variant)
    int m_cnt[2];
    int m_ptr[2];
    int m_field[2];
    int m_wsen[2];
    int m_tst[2];
    logic [0:0] exp_q[$];

    ctc_ws_gen_if #(.PTR_W(4)) bus_a ();
    ctc_ws_gen_if #(.PTR_W(4)) bus_b ();

    ctc_ws_gen #(
        .NDIGIT(ND_A), .DBITS(DBITS), .EXP_DIGITS(ED_A),
        .IS_START(IS_START), .IS_LEN(IS_LEN), .PTR_W(4)
    ) dut_a (
        .cph2 (cph2),
        .rst  (rst_a),
        .bus  (bus_a.master)
    );

    ctc_ws_gen #(
        .NDIGIT(ND_B), .DBITS(DBITS), .EXP_DIGITS(ED_B),
        .IS_START(IS_START), .IS_LEN(IS_LEN), .PTR_W(4)
    ) dut_b (
        .cph2 (cph2),
        .rst  (rst_b),
        .bus  (bus_b.master)
    );

    always #5 cph2 = ~cph2;

    function automatic int ndig(input int w);
        return (w == 0) ? ND_A : ND_B;
    endfunction

    function automatic int expd(input int w);
        return (w == 0) ? ED_A : ED_B;
    endfunction

    function automatic int frame(input int w);
        return ndig(w) * DBITS;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expected ws for a whole frame, from the field's digit span [lo, hi]
    task automatic fill_exp(input int w);
        int n, e, lo, hi;
        n  = ndig(w);
        e  = expd(w);
        lo = 0;
        hi = -1;
        if (m_wsen[w] != 0) begin
            case (m_field[w])
                0: begin lo = m_ptr[w]; hi = m_ptr[w]; end
                1: begin lo = 0;        hi = m_ptr[w]; end
                2: begin lo = e - 1;    hi = e - 1;    end
                3: begin lo = 0;        hi = e - 1;    end
                4: begin lo = n - 1;    hi = n - 1;    end
                5: begin lo = e;        hi = n - 2;    end
                6: begin lo = 0;        hi = n - 1;    end
                default: begin lo = e;  hi = n - 1;    end
            endcase
        end
        exp_q.delete();
        for (int c = 0; c < n * DBITS; c++) begin
            exp_q.push_back((c >= lo * DBITS) && (c < (hi + 1) * DBITS));
        end
    endtask

    task automatic apply_instr(input int w, input logic [9:0] ins);
        int nn, nd;
        nn = int'(ins[9:6]);
        nd = ndig(w);
        m_tst[w]  = 0;
        m_wsen[w] = 0;
        if (ins[1:0] == 2'b10) begin
            m_wsen[w]  = 1;
            m_field[w] = int'(ins[4:2]);
        end else if (ins[1:0] == 2'b00) begin
            case (ins[5:2])
                P_SET: if (nn < nd) m_ptr[w] = nn;
                P_TST: m_tst[w] = (m_ptr[w] == nn) ? 1 : 0;
                P_DEC: m_ptr[w] = (m_ptr[w] + nd - 1) % nd;
                P_INC: m_ptr[w] = (m_ptr[w] + 1) % nd;
                default: ;
            endcase
        end
    endtask

    task automatic drive_is(input int w, input logic b);
        if (w == 0) bus_a.is = b;
        else        bus_b.is = b;
    endtask

    // Enters and leaves on a falling edge; leaves with count 0 visible.
    task automatic reset_dut(input int w, input int ncyc);
        if (w == 0) rst_a = 1'b1;
        else        rst_b = 1'b1;
        drive_is(w, 1'b0);
        repeat (ncyc) begin
            @(posedge cph2);
            @(negedge cph2);
        end
        if (w == 0) begin
            check("rst.ws",    32'(bus_a.ws),       32'd0);
            check("rst.sync",  32'(bus_a.sync),     32'd0);
            check("rst.digit", 32'(bus_a.digit),    32'd0);
            check("rst.tlast", 32'(bus_a.t_last),   32'd0);
            check("rst.ptr",   32'(bus_a.ptr),      32'd0);
            check("rst.tst",   32'(bus_a.tst_flag), 32'd0);
            rst_a = 1'b0;
        end else begin
            check("rst_b.ws",  32'(bus_b.ws),       32'd0);
            check("rst_b.ptr", 32'(bus_b.ptr),      32'd0);
            check("rst_b.tst", 32'(bus_b.tst_flag), 32'd0);
            rst_b = 1'b0;
        end
        m_cnt[w]   = 0;
        m_ptr[w]   = 0;
        m_field[w] = 0;
        m_wsen[w]  = 0;
        m_tst[w]   = 0;
    endtask

    task automatic run_cycles(input int w, input logic [9:0] ins, input int ncyc);
        logic [31:0] o_ws, o_sync, o_digit, o_tl, o_ptr, o_tst;
        logic        e_ws;
        logic        b;
        int          c;
        for (int k = 0; k < ncyc; k++) begin
            c = m_cnt[w];
            if (c == 0) fill_exp(w);
            if (w == 0) begin
                o_ws = 32'(bus_a.ws); o_sync = 32'(bus_a.sync); o_digit = 32'(bus_a.digit);
                o_tl = 32'(bus_a.t_last); o_ptr = 32'(bus_a.ptr); o_tst = 32'(bus_a.tst_flag);
            end else begin
                o_ws = 32'(bus_b.ws); o_sync = 32'(bus_b.sync); o_digit = 32'(bus_b.digit);
                o_tl = 32'(bus_b.t_last); o_ptr = 32'(bus_b.ptr); o_tst = 32'(bus_b.tst_flag);
            end
            e_ws = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
            check($sformatf("c%0d.ws@%0d", w, c),    o_ws,    32'(e_ws));
            check($sformatf("c%0d.sync@%0d", w, c),  o_sync,
                  32'((c >= IS_START) && (c < IS_START + IS_LEN)));
            check($sformatf("c%0d.digit@%0d", w, c), o_digit, 32'(c / DBITS));
            check($sformatf("c%0d.tlast@%0d", w, c), o_tl,    32'((c % DBITS) == DBITS - 1));
            check($sformatf("c%0d.ptr@%0d", w, c),   o_ptr,   32'(m_ptr[w]));
            check($sformatf("c%0d.tst@%0d", w, c),   o_tst,   32'(m_tst[w]));
            // outside the window the line carries noise that must be ignored
            if ((c >= IS_START) && (c < IS_START + IS_LEN)) b = ins[c - IS_START];
            else b = 1'($urandom_range(0, 1));
            drive_is(w, b);
            @(posedge cph2);
            if (c == frame(w) - 1) apply_instr(w, ins);
            m_cnt[w] = (c + 1) % frame(w);
            @(negedge cph2);
        end
    endtask

    task automatic run_frame(input int w, input logic [9:0] ins);
        run_cycles(w, ins, frame(w) - m_cnt[w]);
    endtask

    function automatic logic [9:0] f_ins(input int code);
        return {5'($urandom), 3'(code), 2'b10};
    endfunction

    function automatic logic [9:0] p_ins(input logic [3:0] sub, input int nn);
        return {4'(nn), sub, 2'b00};
    endfunction

    function automatic logic [9:0] junk_ins();
        return {8'($urandom), 1'($urandom_range(0, 1)), 1'b1};
    endfunction

    function automatic logic [9:0] rand_ins(input int w);
        int kind;
        kind = $urandom_range(0, 6);
        case (kind)
            0, 1: return f_ins($urandom_range(0, 7));
            2:    return p_ins(P_SET, $urandom_range(0, 15));
            3:    return p_ins(P_TST, ($urandom_range(0, 1) != 0) ? m_ptr[w] : $urandom_range(0, 15));
            4:    return p_ins(($urandom_range(0, 1) != 0) ? P_INC : P_DEC, $urandom_range(0, 15));
            5:    return {6'($urandom), 4'($urandom), 2'b00};
            default: return junk_ins();
        endcase
    endfunction

    initial begin
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        bus_a.is = 1'b0;
        bus_b.is = 1'b0;
        @(negedge cph2);

        // default geometry: frame timing with idle instructions
        reset_dut(0, 2);
        repeat (3) run_frame(0, junk_ins());

        // set 5 then wp: ws over digits 0..5
        run_frame(0, p_ins(P_SET, 5));
        run_frame(0, f_ins(1));
        run_frame(0, junk_ins());

        // pointer wrap in both directions and out-of-range set
        run_frame(0, p_ins(P_SET, 13));
        run_frame(0, p_ins(P_INC, 0));
        run_frame(0, p_ins(P_DEC, 0));
        run_frame(0, p_ins(P_SET, 14));
        run_frame(0, p_ins(P_SET, 15));
        run_frame(0, junk_ins());

        // pointer test hit, clear, miss
        run_frame(0, p_ins(P_SET, 7));
        run_frame(0, p_ins(P_TST, 7));
        run_frame(0, f_ins(0));
        run_frame(0, p_ins(P_TST, 6));
        run_frame(0, p_ins(P_TST, 7));
        run_frame(0, p_ins(P_TST, 7));
        run_frame(0, junk_ins());

        // every field code in turn
        for (int f = 0; f < 8; f++) run_frame(0, f_ins(f));
        run_frame(0, junk_ins());

        repeat (40) run_frame(0, rand_ins(0));

        // reset inside the fetch window discards the partial word
        run_frame(0, p_ins(P_SET, 9));
        run_frame(0, f_ins(6));
        run_cycles(0, p_ins(P_SET, 3), 50);
        reset_dut(0, 1);
        run_frame(0, f_ins(6));
        run_frame(0, junk_ins());

        // 16-digit, 2-exponent-digit variant
        reset_dut(1, 2);
        run_frame(1, f_ins(3));
        run_frame(1, f_ins(4));
        run_frame(1, f_ins(2));
        run_frame(1, p_ins(P_SET, 15));
        run_frame(1, p_ins(P_INC, 0));
        run_frame(1, p_ins(P_DEC, 0));
        run_frame(1, f_ins(7));
        run_frame(1, f_ins(1));
        repeat (20) run_frame(1, rand_ins(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
